// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: reset PC, fetch FSM states
// and the fetch-buffer entry layout.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are forced to 0.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer holding {pc, inst} entries; push and pop may coincide
// at any fill level, and flush empties it at the next edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues one word request at a time, tracks the single
// outstanding response, and buffers returned instructions for decode.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e  state, state_nxt;
    logic [31:0]   req_pc;
    logic          grant;
    logic          push, pop, full, empty;
    logic [CW-1:0] fifo_cnt;
    fetch_entry_t  wdata, head;

    // Never request during a redirect, so a flushed path leaves nothing in flight.
    always_comb begin
        imem_req  = (state == IDLE) && !redirect_valid && !rst && (fifo_cnt < CW'(DEPTH));
        imem_addr = word_align(pc_cur);
        grant     = imem_req && imem_gnt;
    end

    always_comb begin
        if (rst)                 pc_next = RESET_PC;
        else if (redirect_valid) pc_next = word_align(redirect_pc);
        else if (grant)          pc_next = pc_cur + 32'd4;
        else                     pc_next = pc_cur;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid)         state_nxt = IDLE;
                else if (redirect_valid) state_nxt = DROP;
            end
            DROP: if (imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (grant) req_pc <= imem_addr;
        end
    end

    // A response coinciding with a redirect belongs to the old path and is discarded.
    always_comb begin
        push  = (state == WAIT) && imem_rvalid && !redirect_valid && !rst && (!full || pop);
        pop   = inst_valid && inst_ready && !redirect_valid;
        wdata = '{pc: req_pc, inst: imem_rdata};
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .rdata (head),
        .count (fifo_cnt),
        .full  (full),
        .empty (empty)
    );

    assign inst_valid = !empty && !rst;
    assign inst_out   = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized checks of inst_fetch against a transaction-level model.
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst, imem_gnt, imem_rvalid, inst_ready, redirect_valid;
    logic [31:0] pc_cur, imem_rdata, redirect_pc;
    logic        imem_req, inst_valid;
    logic [31:0] pc_next, imem_addr, inst_out, inst_pc;

    int checks = 0;
    int errors = 0;

    // Model: queue of buffered instructions, outstanding response (0 none, 1 live, 2 stale), PC register.
    fetch_entry_t m_q[$];
    int           m_out;
    logic [31:0]  m_out_pc;
    logic [31:0]  m_pc;

    always #5 clk = ~clk;
    assign pc_cur = m_pc;

    inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check all outputs against the model mid-cycle, then advance one clock.
    task automatic tick();
        logic        exp_req, exp_v;
        logic [31:0] exp_pcn;
        @(negedge clk);
        exp_req = !rst && !redirect_valid && (m_out == 0) && (m_q.size() < DEPTH);
        exp_v   = !rst && (m_q.size() != 0);
        if (rst)                 exp_pcn = RPC;
        else if (redirect_valid) exp_pcn = {redirect_pc[31:2], 2'b00};
        else if (exp_req && imem_gnt) exp_pcn = m_pc + 32'd4;
        else                     exp_pcn = m_pc;
        chk("m_imem_req", imem_req, exp_req);
        chk("m_imem_addr", imem_addr, {m_pc[31:2], 2'b00});
        chk("m_pc_next", pc_next, exp_pcn);
        chk("m_inst_valid", inst_valid, exp_v);
        if (exp_v) begin
            chk("m_inst_out", inst_out, m_q[0].inst);
            chk("m_inst_pc", inst_pc, m_q[0].pc);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_out = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            if (imem_rvalid)      m_out = 0;
            else if (m_out == 1)  m_out = 2;
        end else begin
            if (exp_v && inst_ready) void'(m_q.pop_front());
            if (m_out == 1 && imem_rvalid) m_q.push_back('{pc: m_out_pc, inst: imem_rdata});
            if (m_out != 0 && imem_rvalid) m_out = 0;
            else if (exp_req && imem_gnt) begin
                m_out    = 1;
                m_out_pc = {m_pc[31:2], 2'b00};
            end
        end
        m_pc = exp_pcn;
    endtask

    initial begin
        m_out = 0; m_out_pc = '0; m_pc = RPC;
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_pc_next", pc_next, RPC);
        tick();

        // Basic fetch: grant at t, rvalid at t+1, inst_valid at t+2
        rst = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("basic_req", imem_req, 1);
        chk("basic_addr", imem_addr, 32'h0040_0000);
        chk("basic_pc_next", pc_next, 32'h0040_0004);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
        #1 chk("basic_valid_t1", inst_valid, 0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("basic_valid_t2", inst_valid, 1);
        chk("basic_inst_pc", inst_pc, 32'h0040_0000);
        chk("basic_inst_out", inst_out, 32'h00A0_0093);

        // Backpressure: buffer fills to DEPTH and requests stop
        for (int i = 0; i < 8; i++) begin
            imem_gnt = 1'b1; imem_rvalid = (m_out != 0); imem_rdata = $urandom;
            tick();
        end
        imem_gnt = 1'b1; imem_rvalid = 1'b0;
        #1;
        chk("bp_req_full", imem_req, 0);
        chk("bp_head_pc", inst_pc, 32'h0040_0000);
        tick();
        inst_ready = 1'b1;
        #1 chk("bp_req_popcyc", imem_req, 0);
        tick();
        inst_ready = 1'b0;
        #1;
        chk("bp_req_after_pop", imem_req, 1);
        chk("bp_head_pc2", inst_pc, 32'h0040_0004);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom;
        tick();
        imem_rvalid = 1'b0; inst_ready = 1'b1;
        repeat (3) tick();
        inst_ready = 1'b0;

        // Redirect while a response is pending
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom; tick();
        imem_gnt = 1'b1; imem_rvalid = 1'b0; tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        #1;
        chk("rw_pc_next", pc_next, 32'h0040_0100);
        chk("rw_req", imem_req, 0);
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rw_flushed", inst_valid, 0);
        chk("rw_req_drop", imem_req, 0);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("rw_late_dropped", inst_valid, 0);
        chk("rw_req_next", imem_req, 1);
        chk("rw_addr_next", imem_addr, 32'h0040_0100);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; tick();
        imem_rvalid = 1'b0;
        #1 chk("rw_inst_pc", inst_pc, 32'h0040_0100);

        // Redirect coincident with rvalid
        imem_gnt = 1'b1; tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0050_0000;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("rc_valid", inst_valid, 0);
        chk("rc_req_idle", imem_req, 1);
        chk("rc_addr", imem_addr, 32'h0050_0000);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; tick();
        imem_rvalid = 1'b0;
        #1 chk("rc_inst_pc", inst_pc, 32'h0050_0000);

        // PC wrap at top of address space
        inst_ready = 1'b1; repeat (2) tick();
        inst_ready = 1'b0;
        m_pc = 32'hFFFF_FFFC; imem_gnt = 1'b1;
        #1;
        chk("wrap_pc_next", pc_next, 32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom; tick();
        imem_rvalid = 1'b0;
        #1 chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1; tick();
        inst_ready = 1'b0;

        // Reset while a response is pending
        imem_gnt = 1'b1; tick();
        rst = 1'b1;
        #1;
        chk("rwait_pc_next", pc_next, RPC);
        chk("rwait_valid", inst_valid, 0);
        chk("rwait_req", imem_req, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rwait_req_after", imem_req, 1);
        chk("rwait_addr_after", imem_addr, RPC);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001; tick();
        imem_rvalid = 1'b0;
        #1 chk("rwait_inst_pc", inst_pc, RPC);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 49) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            imem_gnt       = $urandom_range(0, 1) != 0;
            imem_rvalid    = (m_out != 0) && ($urandom_range(0, 2) != 0);
            imem_rdata     = $urandom;
            inst_ready     = $urandom_range(0, 2) != 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
